// File: rtl/pkt_pingpong_ctl.sv
// Ping-pong packet buffer controller: packs 16-bit PCM samples into alternating 512-byte BRAM banks
// and launches the Ethernet transmitter on each full bank. Optional feature macro: PKT_SEQ_EN.
module pkt_pingpong_ctl #(
    parameter int SAMPLES = 240,
    parameter int HDR     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        smp_stb,
    input  logic [15:0] smp_data,
    output logic        smp_rdy,
    output logic        bram_wr_en,
    output logic [9:0]  bram_wr_addr,
    output logic [7:0]  bram_wr_data,
    output logic        tx_start,
    output logic [9:0]  tx_base,
    output logic [9:0]  tx_len,
    input  logic        tx_busy,
    output logic        ovf,
    output logic [7:0]  ovf_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_LO  = 3'd1,
        WR_HI  = 3'd2,
`ifdef PKT_SEQ_EN
        SEQ_LO = 3'd3,
        SEQ_HI = 3'd4,
`endif
        LAUNCH = 3'd5
    } state_t;

    localparam logic [9:0] TX_LEN = 10'(HDR + 2 * SAMPLES);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state, state_nx;
    logic        bank, bank_nx;
    logic [8:0]  idx, idx_nx;
    logic        in_flight, in_flight_nx;
    logic        seen_busy, seen_busy_nx;
    logic [7:0]  hi_byte, hi_byte_nx;
    logic        smp_rdy_nx;
    logic        wr_en_nx;
    logic [9:0]  wr_addr_nx;
    logic [7:0]  wr_data_nx;
    logic        tx_start_nx;
    logic [9:0]  tx_base_nx;
    logic        ovf_nx;
    logic [7:0]  ovf_cnt_nx;
    logic        enter_launch;
    logic [8:0]  pay_off;
    logic        last_smp;
`ifdef PKT_SEQ_EN
    logic [15:0] seq, seq_nx;
`endif

    assign tx_len   = TX_LEN;
    assign pay_off  = 9'(HDR) + {idx[7:0], 1'b0};
    assign last_smp = ((idx + 9'd1) == 9'(SAMPLES));

    // Next-state, bookkeeping and next-output computation; outputs are registered from these
    always_comb begin
        state_nx     = state;
        bank_nx      = bank;
        idx_nx       = idx;
        hi_byte_nx   = hi_byte;
        seen_busy_nx = seen_busy | (in_flight & tx_busy);
        in_flight_nx = in_flight & ~(seen_busy & ~tx_busy);
        wr_en_nx     = 1'b0;
        wr_addr_nx   = bram_wr_addr;
        wr_data_nx   = bram_wr_data;
        tx_start_nx  = 1'b0;
        tx_base_nx   = tx_base;
        ovf_nx       = 1'b0;
        ovf_cnt_nx   = ovf_cnt;
        enter_launch = 1'b0;
`ifdef PKT_SEQ_EN
        seq_nx       = seq;
`endif
        case (state)
            IDLE: begin
                if (smp_stb && smp_rdy) begin
                    state_nx   = WR_LO;
                    hi_byte_nx = smp_data[15:8];
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = {bank, pay_off};
                    wr_data_nx = smp_data[7:0];
                end else begin
                    state_nx = IDLE;
                end
            end
            WR_LO: begin
                state_nx   = WR_HI;
                wr_en_nx   = 1'b1;
                wr_addr_nx = {bank, pay_off + 9'd1};
                wr_data_nx = hi_byte;
            end
            WR_HI: begin
                idx_nx = idx + 9'd1;
                if (last_smp) begin
`ifdef PKT_SEQ_EN
                    state_nx   = SEQ_LO;
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = {bank, 9'(HDR - 2)};
                    wr_data_nx = seq[15:8];
`else
                    enter_launch = 1'b1;
`endif
                end else begin
                    state_nx = IDLE;
                end
            end
`ifdef PKT_SEQ_EN
            SEQ_LO: begin
                state_nx   = SEQ_HI;
                wr_en_nx   = 1'b1;
                wr_addr_nx = {bank, 9'(HDR - 1)};
                wr_data_nx = seq[7:0];
            end
            SEQ_HI: begin
                enter_launch = 1'b1;
            end
`endif
            LAUNCH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Decision uses in_flight as registered now, so a clear landing on the LAUNCH edge is missed
        if (enter_launch) begin
            state_nx = LAUNCH;
            idx_nx   = 9'd0;
`ifdef PKT_SEQ_EN
            seq_nx   = seq + 16'd1;
`endif
            if (!in_flight && !tx_busy) begin
                tx_start_nx  = 1'b1;
                tx_base_nx   = {bank, 9'd0};
                in_flight_nx = 1'b1;
                seen_busy_nx = 1'b0;
                bank_nx      = ~bank;
            end else begin
                ovf_nx     = 1'b1;
                ovf_cnt_nx = sat_inc8(ovf_cnt);
            end
        end else begin
            ovf_nx = 1'b0;
        end

        smp_rdy_nx = (state_nx == IDLE);
    end

    // State, bookkeeping and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bank         <= 1'b0;
            idx          <= 9'd0;
            in_flight    <= 1'b0;
            seen_busy    <= 1'b0;
            hi_byte      <= 8'd0;
            smp_rdy      <= 1'b1;
            bram_wr_en   <= 1'b0;
            bram_wr_addr <= 10'd0;
            bram_wr_data <= 8'd0;
            tx_start     <= 1'b0;
            tx_base      <= 10'd0;
            ovf          <= 1'b0;
            ovf_cnt      <= 8'd0;
`ifdef PKT_SEQ_EN
            seq          <= 16'd0;
`endif
        end else begin
            state        <= state_nx;
            bank         <= bank_nx;
            idx          <= idx_nx;
            in_flight    <= in_flight_nx;
            seen_busy    <= seen_busy_nx;
            hi_byte      <= hi_byte_nx;
            smp_rdy      <= smp_rdy_nx;
            bram_wr_en   <= wr_en_nx;
            bram_wr_addr <= wr_addr_nx;
            bram_wr_data <= wr_data_nx;
            tx_start     <= tx_start_nx;
            tx_base      <= tx_base_nx;
            ovf          <= ovf_nx;
            ovf_cnt      <= ovf_cnt_nx;
`ifdef PKT_SEQ_EN
            seq          <= seq_nx;
`endif
        end
    end

endmodule

// File: doc/pkt_pingpong_ctl.md
# pkt_pingpong_ctl

Ping-pong packet buffer controller between the PCM sample stream and the Ethernet transmitter. Splits the 1024-byte Ethernet packet BRAM into two 512-byte banks. Packs 16-bit PCM samples byte-wise into the bank being filled. When that bank is full, hands it to the transmitter while the other bank starts filling, so sample capture never has to wait for a transmit to finish. It owns the BRAM write port and the transmitter start handshake. It replaces the inline write/launch sequencing in the top-level sender state machine.

## Interface
Parameters:
- `SAMPLES`, 240, 16-bit samples per packet. Constraint: `HDR + 2*SAMPLES <= 512`.
- `HDR`, 16, header bytes at the start of each bank. Payload starts at bank offset `HDR`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  synchronous reset, active low.
- `smp_stb`  in  1  one-cycle sample strobe. Only valid while `smp_rdy` is 1.
- `smp_data`  in  16  sample, captured on `smp_stb & smp_rdy`.
- `smp_rdy`  out  1  controller can accept a sample.
- `bram_wr_en`  out  1  BRAM write enable.
- `bram_wr_addr`  out  10  BRAM write address. Bit 9 is the bank.
- `bram_wr_data`  out  8  BRAM write data.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_base`  out  10  bank base address (0 or 512); valid with `tx_start`.
- `tx_len`  out  10  frame length, constant `HDR + 2*SAMPLES`.
- `tx_busy`  in  1  transmitter busy.
- `ovf`  out  1  one-cycle pulse when a filled bank is discarded.
- `ovf_cnt`  out  8  overrun count; saturates at 255.

## Operation
- Reset values:
  - Outputs: `smp_rdy` = 1; `bram_wr_en`, `tx_start`, `ovf` = 0; `bram_wr_addr`, `bram_wr_data`, `tx_base`, `ovf_cnt` = 0.
  - Internal: `bank` = 0, `idx` = 0, `in_flight` = 0, `seen_busy` = 0, `seq` = 0.
- All outputs are registered.
- States:
  - IDLE → WR_LO on `smp_stb & smp_rdy`. Latches `smp_data`.
  - WR_LO: writes the low byte to `bank*512 + HDR + 2*idx`. Goes to WR_HI.
  - WR_HI: writes the high byte to the same address + 1. Then `idx++`.
    - If `idx` is now `SAMPLES`, go to SEQ_LO (when `PKT_SEQ_EN` is defined) or LAUNCH (when not).
    - Otherwise go to IDLE.
  - SEQ_LO: writes `seq[15:8]` at bank offset `HDR-2`. Goes to SEQ_HI.
  - SEQ_HI: writes `seq[7:0]` at bank offset `HDR-1`. Goes to LAUNCH.
  - LAUNCH (one cycle); `seq++` in either case:
    - If `!in_flight && !tx_busy`: pulse `tx_start` with `tx_base = bank*512`. Set `in_flight`, clear `seen_busy`, toggle `bank`.
    - Otherwise (overrun): keep `bank`, pulse `ovf`, increment `ovf_cnt` (saturating).
    - Then `idx` ← 0 and go to IDLE.
- `smp_rdy` is 1 only in IDLE. A strobe while `smp_rdy` is 0 is ignored: no write, no counter change.
- `in_flight` tracking:
  - `seen_busy` sets on any cycle with `in_flight & tx_busy`.
  - `in_flight` clears on the first cycle with `seen_busy & !tx_busy`.
- Arithmetic:
  - `idx` is 9 bits wide.
  - `seq` is 16 bits and wraps 0xFFFF → 0x0000.
  - Addresses are `{bank, 9'(offset)}`.
- Header bytes `0..HDR-3` are never written by this block.

## Timing
- Sample accepted at cycle t: low-byte write in t+1, high-byte write in t+2, `smp_rdy` = 1 again in t+3.
- Accept of the filling sample (the `SAMPLES`-th) at t:
  - With `PKT_SEQ_EN`: seq writes in t+3 and t+4, `tx_start` or `ovf` in t+5, `smp_rdy` = 1 in t+6.
  - Without `PKT_SEQ_EN`: `tx_start` or `ovf` in t+3, `smp_rdy` = 1 in t+4.
- The launch decision samples `in_flight` and `tx_busy` as registered at the LAUNCH cycle.
- If `in_flight` clears in the LAUNCH cycle itself, that clear is not seen: the bank is discarded.
- `tx_busy` may rise any number of cycles after `tx_start`. `in_flight` stays set until busy has been seen high and then low.
- `rst_n` low mid-packet: everything returns to reset values on the next edge and the partial bank is abandoned.
  - `in_flight` = 0 after reset, but a transmit still in progress holds `tx_busy` high, so launches remain guarded by `tx_busy`.

## Configuration
- `PKT_SEQ_EN` defined: each filled bank gets a big-endian 16-bit sequence number at offsets `HDR-2`/`HDR-1`. `seq` advances on every filled bank, launched or discarded, so the receiver sees a gap on overrun.
- `PKT_SEQ_EN` undefined: the SEQ_LO and SEQ_HI states are absent, LAUNCH directly follows the last WR_HI, and nothing is written below offset `HDR`.

## Test plan
Scenarios use `SAMPLES`=4, `HDR`=16.
- Reset, then sample 0xBEEF → writes 0xEF@16 in t+1, 0xBE@17 in t+2; `smp_rdy` = 1 at t+3.
- 4 samples with `tx_busy` = 0 and `PKT_SEQ_EN` defined → writes 0x00@14 then 0x00@15; `tx_start` with `tx_base` = 0, `tx_len` = 24. The next sample is written at 528.
- Fill bank 1 while the bank 0 transmit holds `tx_busy` = 1 → `ovf` pulse, `ovf_cnt` = 1, no `tx_start`. The next sample is written at 528 again, and its seq bytes are 0x00 then 0x02.
- `smp_stb` in the cycle after an accept (`smp_rdy` = 0) → no extra BRAM write; `idx` unchanged.
- 300 consecutive overruns → `ovf_cnt` holds 255.
- `rst_n` low after 2 of 4 samples → all outputs are at reset values on the next cycle; the next sample is written at 16.
